// File: rtl/regbank_pkg.sv
// Shared widths and the write-back entry type for the register-bank write path.
package regbank_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 32;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : regbank_pkg

// File: rtl/regbank_writeback_if.sv
// Valid/ready result channel from the execute/memory stages into the
// write-back queue. The producer uses the master modport and the queue uses
// the slave modport.
interface regbank_writeback_if
  import regbank_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic              InValid;
  logic              InReady;
  logic [ADDR_W-1:0] InRegister;
  logic [DATA_W-1:0] InData;

  modport master (
    output InValid,
    output InRegister,
    output InData,
    input  InReady
  );

  modport slave (
    input  InValid,
    input  InRegister,
    input  InData,
    output InReady
  );

endinterface : regbank_writeback_if

// File: rtl/wb_fifo.sv
// Generic circular FIFO for write-back entries. It exposes the head entry,
// the fill level, and a read-all view in age order (index 0 = oldest) so the
// parent can search the pending entries.
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  entry_t                  wdata_i,
  input  logic                    pop_i,
  output entry_t                  rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [CNT_W-1:0]        count_o,
  output entry_t [DEPTH-1:0]      view_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Requests are ignored when they would overflow or underflow the storage.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and count values; pointer widths make wrap modulo DEPTH free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; an empty count already marks every slot invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Age-ordered view of all slots, starting at the head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

endmodule : wb_fifo

// File: rtl/regbank_writeback.sv
// Write-back queue in front of the register bank write port.
// Accepts results over a valid/ready channel, drops writes to register 0,
// buffers the rest in order and drains one registered write per cycle unless
// Hold is high.
// Optional feature macro: REGBANK_WB_FORWARD_EN enables newest-value lookup
// for the decode stage; without it LookupHit/LookupData are tied low.
module regbank_writeback
  import regbank_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = REG_ADDR_W,
  parameter int  DATA_W = REG_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regbank_writeback_if.slave   in_if,
  input  logic                 Hold,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    WriteRegister,
  output logic [DATA_W-1:0]    WriteData,
  output logic                 Full,
  output logic                 Empty,
  output logic [CNT_W-1:0]     Count,
  input  logic [ADDR_W-1:0]    LookupRegister,
  output logic                 LookupHit,
  output logic [DATA_W-1:0]    LookupData
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               in_entry;
  entry_t               head;
  entry_t [DEPTH-1:0]   fifo_view;
  logic                 accept, push, pop;

  logic                 regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;

  // Ready comes only from the registered fill level; a pop in the same cycle
  // does not open the input.
  assign in_if.InReady = !Full;
  assign accept        = in_if.InValid && in_if.InReady;
  assign push          = accept && (in_if.InRegister != '0);
  assign pop           = !Hold && !Empty;
  assign in_entry      = '{addr: in_if.InRegister, data: in_if.InData};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (Full),
    .empty_o (Empty),
    .count_o (Count),
    .view_o  (fifo_view)
  );

  // Output stage next state: strobe only on a pop, address/data hold otherwise.
  always_comb begin
    regwrite_d = pop;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (pop) begin
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  // Registered write port to the register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = waddr_q;
  assign WriteData     = wdata_q;

`ifdef REGBANK_WB_FORWARD_EN
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  // Newest-wins search: output stage first, then queue oldest to newest so
  // later matches override earlier ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (LookupRegister != '0) begin
      if (regwrite_q && (waddr_q == LookupRegister)) begin
        lookup_hit  = 1'b1;
        lookup_data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < Count) && (fifo_view[i].addr == LookupRegister)) begin
          lookup_hit  = 1'b1;
          lookup_data = fifo_view[i].data;
        end
      end
    end
  end

  assign LookupHit  = lookup_hit;
  assign LookupData = lookup_data;
`else
  logic unused_lookup;

  assign LookupHit     = 1'b0;
  assign LookupData    = '0;
  assign unused_lookup = ^{LookupRegister, fifo_view};
`endif

endmodule : regbank_writeback

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback: reset values, latency, hold/fill,
// register-0 drop, lookup, full-throughput streaming and mid-burst reset.
module tb_regbank_writeback;

`ifdef REGBANK_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        Hold;
  logic        RegWrite;
  logic [5:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Full, Empty;
  logic [2:0]  Count;
  logic [5:0]  LookupRegister;
  logic        LookupHit;
  logic [31:0] LookupData;

  int n_checks = 0;
  int n_pass   = 0;

  regbank_writeback_if #(.ADDR_W(6), .DATA_W(32)) in_if ();

  regbank_writeback #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_if          (in_if),
    .Hold           (Hold),
    .RegWrite       (RegWrite),
    .WriteRegister  (WriteRegister),
    .WriteData      (WriteData),
    .Full           (Full),
    .Empty          (Empty),
    .Count          (Count),
    .LookupRegister (LookupRegister),
    .LookupHit      (LookupHit),
    .LookupData     (LookupData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] r, input logic [31:0] d);
    in_if.InValid    = v;
    in_if.InRegister = r;
    in_if.InData     = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_regwrite"}, RegWrite, 0);
    check({tag, "_wreg"}, WriteRegister, 0);
    check({tag, "_wdata"}, WriteData, 0);
    check({tag, "_count"}, Count, 0);
    check({tag, "_empty"}, Empty, 1);
    check({tag, "_full"}, Full, 0);
    check({tag, "_ready"}, in_if.InReady, 1);
    check({tag, "_hit"}, LookupHit, 0);
  endtask

  logic [37:0] exp_q [$];
  logic [37:0] e;
  int          sent, writes;
  bit          accepted, done;

  initial begin
    reset = 1'b1;
    Hold = 1'b0;
    LookupRegister = '0;
    drive(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;

    // Single write: accepted at edge N, strobed during N+1..N+2.
    drive(1, 6'd1, 32'd100);
    tick();
    drive(0, 0, 0);
    check("lat_not_yet", RegWrite, 0);
    check("lat_count1", Count, 1);
    tick();
    check("lat_regwrite", RegWrite, 1);
    check("lat_wreg", WriteRegister, 1);
    check("lat_wdata", WriteData, 100);
    tick();
    check("lat_drop", RegWrite, 0);
    check("lat_hold_wreg", WriteRegister, 1);

    // Fill under Hold, then drain in order.
    Hold = 1'b1;
    for (int r = 2; r <= 5; r++) begin
      drive(1, 6'(r), 32'(r));
      tick();
      check("hold_no_write", RegWrite, 0);
    end
    drive(0, 0, 0);
    check("fill_full", Full, 1);
    check("fill_ready", in_if.InReady, 0);
    check("fill_count", Count, 4);
    Hold = 1'b0;
    for (int r = 2; r <= 5; r++) begin
      tick();
      check("drain_regwrite", RegWrite, 1);
      check("drain_wreg", WriteRegister, r);
      check("drain_wdata", WriteData, r);
    end
    check("drain_empty", Empty, 1);
    tick();
    check("drain_idle", RegWrite, 0);

    // Register 0 is acknowledged but dropped.
    drive(1, 6'd0, 32'd55);
    check("r0_ready", in_if.InReady, 1);
    tick();
    drive(0, 0, 0);
    check("r0_count", Count, 0);
    check("r0_no_write", RegWrite, 0);
    tick();
    check("r0_still_no_write", RegWrite, 0);
    check("r0_empty", Empty, 1);

    // Lookup: newest duplicate wins, misses and register 0 read as zero.
    Hold = 1'b1;
    drive(1, 6'd7, 32'd10);
    tick();
    drive(1, 6'd7, 32'd20);
    tick();
    drive(0, 0, 0);
    LookupRegister = 6'd7;
    #1;
    check("lk7_hit", LookupHit, FWD);
    check("lk7_data", LookupData, FWD ? 20 : 0);
    LookupRegister = 6'd8;
    #1;
    check("lk8_hit", LookupHit, 0);
    check("lk8_data", LookupData, 0);
    LookupRegister = 6'd0;
    #1;
    check("lk0_hit", LookupHit, 0);
    LookupRegister = 6'd7;
    Hold = 1'b0;
    tick();
    check("dup1_wreg", WriteRegister, 7);
    check("dup1_wdata", WriteData, 10);
    check("dup1_lk_data", LookupData, FWD ? 20 : 0);
    tick();
    check("dup2_wdata", WriteData, 20);
    check("dup2_regwrite", RegWrite, 1);
    check("outstage_hit", LookupHit, FWD);
    check("outstage_data", LookupData, FWD ? 20 : 0);
    tick();
    check("idle_hit", LookupHit, 0);
    LookupRegister = 6'd0;

    // Full, then stream with Hold low and InValid held.
    Hold = 1'b1;
    for (int r = 10; r <= 13; r++) begin
      drive(1, 6'(r), 32'h100 + 32'(r));
      tick();
      exp_q.push_back({6'(r), 32'h100 + 32'(r)});
    end
    sent = 0;
    writes = 0;
    done = 0;
    Hold = 1'b0;
    drive(1, 6'd14, 32'h114);
    check("stream_full", Full, 1);
    check("stream_full_ready", in_if.InReady, 0);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      accepted = in_if.InValid && in_if.InReady;
      tick();
      if (accepted) begin
        exp_q.push_back({in_if.InRegister, in_if.InData});
        sent++;
      end
      if (RegWrite) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("stream_extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_wreg", WriteRegister, e[37:32]);
          check("stream_wdata", WriteData, e[31:0]);
        end
      end
      check("stream_count_le_depth", Count <= 3'd4, 1);
      if (sent < 6) drive(1, 6'(14 + sent), 32'h100 + 32'(14 + sent));
      else drive(0, 0, 0);
      if (sent == 6 && exp_q.size() == 0 && Empty) done = 1;
    end
    check("stream_writes", writes, 10);
    check("stream_left", exp_q.size(), 0);

    // Reset mid-burst discards pending writes asynchronously.
    Hold = 1'b1;
    for (int r = 20; r <= 22; r++) begin
      drive(1, 6'(r), 32'(r));
      tick();
    end
    drive(0, 0, 0);
    check("mid_count3", Count, 3);
    Hold = 1'b0;
    tick();
    check("mid_regwrite", RegWrite, 1);
    check("mid_wreg", WriteRegister, 20);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_no_write", RegWrite, 0);
    check("post_rst_count", Count, 0);
    tick();
    check("post_rst_no_write2", RegWrite, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regbank_writeback

// File: doc/regbank_writeback.md
# regbank_writeback

Write-back queue sitting in front of the register bank's write port. It accepts register results from the execute/memory stages over a valid/ready handshake and buffers them in a small FIFO. It then drives RegWrite/WriteRegister/WriteData into the register bank, one write per cycle, unless held. Optionally it forwards the newest pending value for a looked-up register, so the decode stage can read results not yet written.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 6, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- InValid  in  1  producer offers a result
- InReady  out  1  queue can accept (= not Full)
- InRegister  in  ADDR_W  destination register
- InData  in  DATA_W  result value
- Hold  in  1  suppress draining this cycle
- RegWrite  out  1  write strobe to register bank (registered)
- WriteRegister  out  ADDR_W  write address (registered)
- WriteData  out  DATA_W  write data (registered)
- Full  out  1  count == DEPTH
- Empty  out  1  count == 0
- Count  out  $clog2(DEPTH)+1  occupied entries
- LookupRegister  in  ADDR_W  register being decoded
- LookupHit  out  1  pending value exists for LookupRegister (combinational)
- LookupData  out  DATA_W  newest pending value

## Operation
- Accept when InValid && InReady at a rising edge. InRegister == 0: the handshake completes but nothing is enqueued (register 0 is never written).
- Drain: on each edge with !Hold && !Empty, pop the head into the output register and set RegWrite=1. Otherwise RegWrite=0. WriteRegister/WriteData hold their last values when RegWrite=0.
- Push and pop in the same cycle are both allowed. Count is unchanged.
- InReady = !Full from registered count. No combinational full-bypass.
- Entries drain strictly in acceptance order. Duplicate destinations are kept and written in order.
- Lookup priority, newest first: queued entries (tail to head), then output stage if RegWrite=1. LookupRegister == 0 never hits. No hit: LookupHit=0, LookupData=0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, Count=0, Empty=1, Full=0, InReady=1, LookupHit=0. All entries are discarded, and reset mid-burst loses pending writes.
- Latency: a result accepted at edge N into an empty queue with Hold low is popped at edge N+1, so RegWrite is high during cycle N+1 to N+2.
- Throughput: one write per cycle sustained.
- A Hold assertion takes effect at the next edge. The output register shows RegWrite=0 for every held edge.
- Full with a simultaneous pop: InReady is still 0 that cycle.

## Configuration
- REGBANK_WB_FORWARD_EN defined: lookup logic is present as described.
- Undefined: LookupHit and LookupData are tied to 0, and LookupRegister is unused.

## Structure
- Package regbank_pkg: REG_ADDR_W=6, REG_DATA_W=32, typedef wb_entry_t struct {addr, data}.
- Sub-module wb_fifo: generic storage with pointers, count, Full/Empty and a read-all port for the lookup. regbank_writeback adds the register-0 filter, the output register, and forwarding.

## Test plan
- Reset, then accept (r1, 100) with Hold=0 -> RegWrite=1, WriteRegister=1, WriteData=100 exactly one cycle later, then RegWrite=0.
- Hold=1, push r2..r5 (values 2..5) -> Full=1, InReady=0, Count=4. Release Hold -> four consecutive writes r2..r5 in order, then Empty=1.
- Push (r0, 55) -> handshake completes, Count stays 0, no RegWrite.
- With forwarding enabled, Hold=1, push (r7, 10) then (r7, 20), LookupRegister=7 -> LookupHit=1, LookupData=20. Lookup r8 -> Hit=0, Data=0.
- Full with Hold=0 and InValid held -> pop and push interleave, Count never exceeds DEPTH, and no entry is lost or duplicated.
- Assert reset with 3 entries queued -> all outputs at reset values asynchronously, and no RegWrite after reset deasserts.
